usb_uart_rx_buffer: RTL and testbench



---
 rtl/usb_uart_rx_buffer_pkg.sv | 11 +
 rtl/usb_uart_rx_buffer_mem.sv | 27 ++
 rtl/usb_uart_rx_buffer.sv | 105 ++++++++++
 tb/tb_usb_uart_rx_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_uart_rx_buffer_pkg.sv
// Shared defaults and types for the USB CDC serial bridge byte buffers.
// The TX-side buffer uses the same defaults.
package usb_uart_rx_buffer_pkg;

    localparam int DEF_ADDR_WIDTH  = 6;
    localparam int DEF_ALMOST_FULL = 48;
    localparam int DEF_DROP_WIDTH  = 16;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/usb_uart_rx_buffer_mem.sv
// Simple dual-port byte RAM: one synchronous write port and one combinational read port.
// No reset on the array, so the storage can map onto block RAM.
module usb_uart_rx_mem
    import usb_uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/usb_uart_rx_buffer.sv
// Receive byte buffer for the USB CDC bridge: RAM FIFO plus output register,
// valid/ready consumer side, and overrun accounting for the non-backpressured USB core.
module usb_uart_rx_buffer
    import usb_uart_rx_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL = DEF_ALMOST_FULL,
    parameter int DROP_WIDTH  = DEF_DROP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_strobe,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [DROP_WIDTH-1:0] drop_count,
    input  logic                  clear_overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL   = (ADDR_WIDTH + 1)'(ALMOST_FULL);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [7:0]            ram_rd_data;
    logic                  ram_rd;
    logic                  ram_wr;
    logic                  drop;

    function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] value);
        return (&value) ? value : value + DROP_WIDTH'(1);
    endfunction

    // The output register refills whenever it is empty or being consumed this cycle.
    assign ram_rd = (!out_valid || out_ready) && (level != '0);
    // A full RAM still accepts a byte if a slot is freed at the same edge.
    assign ram_wr = rx_strobe && ((level < FULL_LEVEL) || ram_rd);
    assign drop   = rx_strobe && !ram_wr;

    assign almost_full = (level >= AF_LEVEL);

    usb_uart_rx_mem #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (ram_wr),
        .wr_addr (wr_ptr),
        .wr_data (rx_data),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (ram_wr) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({ram_wr, ram_rd})
                2'b10:   level <= level + (ADDR_WIDTH + 1)'(1);
                2'b01:   level <= level - (ADDR_WIDTH + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (ram_rd) begin
            out_data  <= ram_rd_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= clear_overflow ? DROP_WIDTH'(1) : sat_inc(drop_count);
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_usb_uart_rx_buffer.sv
// Bench for usb_uart_rx_buffer: directed scenarios then randomized traffic, checked
// against a queue-based model; a second instance with a 4-bit drop counter shares the stimulus.
module tb_usb_uart_rx_buffer;

    localparam int DEPTH = 64;
    localparam int AF    = 48;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_strobe = 1'b0;
    logic        out_ready = 1'b0;
    logic        clear_overflow = 1'b0;

    logic [7:0]  out_data, out_data4;
    logic        out_valid, out_valid4;
    logic [6:0]  level, level4;
    logic        almost_full, almost_full4;
    logic        overflow, overflow4;
    logic [15:0] drop_count;
    logic [3:0]  drop_count4;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: bytes held in RAM, plus the presented head byte.
    logic [7:0] ram_q[$];
    logic [7:0] m_head;
    logic       m_hv;
    logic       m_ovf;
    int         m_drop;
    int         m_drop4;

    always #5 clk = ~clk;

    usb_uart_rx_buffer dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .almost_full(almost_full), .overflow(overflow),
        .drop_count(drop_count), .clear_overflow(clear_overflow)
    );

    usb_uart_rx_buffer #(.DROP_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .level(level4), .almost_full(almost_full4), .overflow(overflow4),
        .drop_count(drop_count4), .clear_overflow(clear_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ram_q.delete();
        m_head  = '0;
        m_hv    = 1'b0;
        m_ovf   = 1'b0;
        m_drop  = 0;
        m_drop4 = 0;
    endtask

    task automatic model_edge();
        bit rd, acc, drop;
        rd   = (!m_hv || out_ready) && (ram_q.size() > 0);
        acc  = rx_strobe && ((ram_q.size() < DEPTH) || rd);
        drop = rx_strobe && !acc;
        if (rd) begin
            m_head = ram_q.pop_front();
            m_hv   = 1'b1;
        end else if (m_hv && out_ready) begin
            m_hv = 1'b0;
        end
        if (acc) ram_q.push_back(rx_data);
        if (drop) begin
            m_ovf = 1'b1;
            if (clear_overflow) begin
                m_drop  = 1;
                m_drop4 = 1;
            end else begin
                m_drop  = (m_drop  < 65535) ? m_drop  + 1 : 65535;
                m_drop4 = (m_drop4 < 15)    ? m_drop4 + 1 : 15;
            end
        end else if (clear_overflow) begin
            m_ovf   = 1'b0;
            m_drop  = 0;
            m_drop4 = 0;
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(m_hv));
        if (m_hv) chk("out_data", 32'(out_data), 32'(m_head));
        chk("level", 32'(level), 32'(ram_q.size()));
        chk("almost_full", 32'(almost_full), 32'(ram_q.size() >= AF));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("out_valid4", 32'(out_valid4), 32'(m_hv));
        if (m_hv) chk("out_data4", 32'(out_data4), 32'(m_head));
        chk("level4", 32'(level4), 32'(ram_q.size()));
        chk("overflow4", 32'(overflow4), 32'(m_ovf));
        chk("drop_count4", 32'(drop_count4), 32'(m_drop4));
    endtask

    task automatic step(input logic s, input logic [7:0] d, input logic r, input logic c);
        rx_strobe      = s;
        rx_data        = d;
        out_ready      = r;
        clear_overflow = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_af"}, 32'(almost_full), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_drop"}, 32'(drop_count), 32'd0);
        chk({tag, "_drop4"}, 32'(drop_count4), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int p_strobe, p_ready;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;

        // Single byte through an empty buffer.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("single_valid_e0", 32'(out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_level", 32'(level), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_drain", 32'(out_valid), 32'd0);

        // Burst of 64, then drain in order at one byte per cycle.
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("burst_head", 32'(out_data), 32'h00);
        chk("burst_level", 32'(level), 32'd63);
        chk("burst_af", 32'(almost_full), 32'd1);
        for (int i = 0; i < 64; i++) begin
            chk("burst_order", 32'(out_data), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("burst_empty", 32'(out_valid), 32'd0);
        chk("burst_ovf", 32'(overflow), 32'd0);

        // Overrun: 66 strobes with the consumer stalled.
        for (int i = 0; i < 66; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("ovr_head", 32'(out_data), 32'h00);
        chk("ovr_level", 32'(level), 32'd64);
        chk("ovr_flag", 32'(overflow), 32'd1);
        chk("ovr_drop", 32'(drop_count), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_flag", 32'(overflow), 32'd0);
        chk("clr_drop", 32'(drop_count), 32'd0);

        // Full with a simultaneous pop accepts the byte.
        step(1'b1, 8'hC3, 1'b1, 1'b0);
        chk("fullpop_level", 32'(level), 32'd64);
        chk("fullpop_drop", 32'(drop_count), 32'd0);
        chk("fullpop_head", 32'(out_data), 32'h01);

        // Saturation of the narrow counter, then a clear racing a drop.
        for (int i = 0; i < 20; i++) step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("sat_drop16", 32'(drop_count), 32'd20);
        chk("sat_drop4", 32'(drop_count4), 32'd15);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("race_ovf", 32'(overflow), 32'd1);
        chk("race_drop", 32'(drop_count), 32'd1);
        chk("race_drop4", 32'(drop_count4), 32'd1);

        // Asynchronous reset mid-stream.
        reset = 1'b0;
        #1;
        model_reset();
        check_zero("rst_full");
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 11; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        chk("mid_level", 32'(level), 32'd10);
        chk("mid_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        check_zero("rst_mid");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_data", 32'(out_data), 32'h5A);
        chk("post_rst_valid", 32'(out_valid), 32'd1);

        // Randomized traffic in phases of differing producer/consumer pressure.
        for (int ph = 0; ph < 16; ph++) begin
            p_strobe = int'($urandom_range(100));
            p_ready  = int'($urandom_range(100));
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(99) < p_strobe, 8'($urandom),
                     $urandom_range(99) < p_ready, $urandom_range(99) < 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
